tty_rx_os: RTL and testbench
============================

TTY_RX_OS -- requirements
Module: tty_rx_os

Interface
REQ-001 Parameter DIV, default 25, clk cycles per 1/16 bit (200 MHz clk, 500 kbaud); legal range 2..65535.
REQ-002 Parameter DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  sole clock, all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 valid  input  1  consumer requests one byte.
REQ-007 ready  output  1  one-cycle pulse; data holds the popped byte.
REQ-008 data  output  8  FIFO head byte, registered.
REQ-009 count  output  $clog2(DEPTH)+1  bytes currently held.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 brk  output  1  one-cycle pulse; frame error with all data bits 0.
REQ-012 overrun  output  1  one-cycle pulse; good byte arrived while FIFO full.

Function
REQ-013 rx passes a 2-flop synchronizer, both flops resetting to 1; all decisions use the second-flop output (rs).
REQ-014 Tick counter: reloads DIV-1, decrements every clk, asserts tick at 0; runs only outside IDLE and restarts on the IDLE->START transition.
REQ-015 Sample counter: 4 bits, increments per tick, wraps 15->0; wrap ends a bit period.
REQ-016 Bit value = majority of rs at samples 7, 8, 9 of the bit.
REQ-017 FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-018 IDLE->START on a rs 1->0 edge; sample counter cleared.
REQ-019 START: majority 1 -> IDLE (glitch, nothing reported); majority 0 -> DATA at the bit-end wrap.
REQ-020 DATA: 8 bits shifted in LSB first; after bit 7 -> STOP.
REQ-021 STOP: at sample 9 decide and -> IDLE at once, without waiting for the wrap, so back-to-back frames are not lost.
REQ-022 Stop majority 1: push byte; if FIFO full, drop the byte and pulse overrun; FIFO contents unchanged.
REQ-023 Stop majority 0: no push; pulse frame_err; also pulse brk if the byte is 0x00.
REQ-024 Pop when valid && count!=0 && !ready; next cycle ready=1, data=popped byte; at most one pop per two cycles.
REQ-025 valid with count==0: no effect, no pulse; request is not remembered.
REQ-026 Push and pop in the same cycle: both happen, count unchanged; on a full FIFO the push succeeds because the pop frees the slot.
REQ-027 Pointers are $clog2(DEPTH) bits wide and wrap naturally; count = pushes - pops, never exceeds DEPTH.
REQ-028 data holds its last value until the next pop.

Reset
REQ-029 rst high: FSM IDLE, counters 0, FIFO empty, count=0, ready=0, data=0x00, frame_err=brk=overrun=0, synchronizer flops=1.
REQ-030 rst mid-frame: the partial byte is discarded, no pulses are issued, and reception restarts at the next falling edge after rst deasserts.

Structure
REQ-031 Shared package holds the FSM state enum and the default baud constants (DIV=25, 16x oversample).
REQ-032 FIFO is one sub-module, tty_fifo (DEPTH, 8-bit, push/pop/count), also reusable for a buffered transmitter.

Verification
REQ-033 DIV=4; send 0x55, then valid -> one ready pulse, data=0x55, count 1->0.
REQ-034 Send 0xA3 with a 0.5-bit start glitch first -> glitch ignored; exactly one byte 0xA3 received.
REQ-035 Send 0x3C with stop bit driven low -> frame_err pulse, no push, count=0; send 0x00 with low stop -> frame_err and brk pulse.
REQ-036 DEPTH=8; send 9 bytes 0x01..0x09 with no valid -> count=8, overrun once on the 9th byte; drain returns 0x01..0x08 in order.
REQ-037 FIFO full; pop in the same cycle as the 9th stop decision -> no overrun, count stays 8.
REQ-038 Assert rst during data bit 4 of 0xFF -> all outputs at reset values; next 0x81 is received correctly.

Source files
------------

// File: rtl/tty_rx_os_pkg.sv
// ---------------------------------------------------------------------------
// tty_rx_os_pkg
// Shared definitions for the oversampling serial receiver:
//   - rx_state_t    : receiver FSM state encoding
//   - DEFAULT_DIV   : clk cycles per 1/16 bit (200 MHz clk, 500 kbaud)
//   - OVERSAMPLE    : samples per bit period
//   - DEFAULT_DEPTH : receive FIFO entries
//   - SAMPLE_*      : sample indices used for the per-bit majority vote
//   - maj3()        : 2-of-3 majority helper
// ---------------------------------------------------------------------------
package tty_rx_os_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_DIV   = 25;
  localparam int OVERSAMPLE    = 16;
  localparam int DEFAULT_DEPTH = 8;

  // The vote uses the three samples around the middle of the bit.
  localparam logic [3:0] SAMPLE_A    = 4'd7;
  localparam logic [3:0] SAMPLE_B    = 4'd8;
  localparam logic [3:0] SAMPLE_C    = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tty_rx_os_if.sv
// ---------------------------------------------------------------------------
// tty_rx_os_if
// Consumer-side bus of the receiver.
//   valid     : consumer requests one byte
//   ready     : one-cycle pulse, data holds the popped byte
//   data      : FIFO head byte (registered)
//   count     : bytes currently held
//   frame_err : one-cycle pulse, stop bit sampled low
//   brk       : one-cycle pulse, framing error with all data bits zero
//   overrun   : one-cycle pulse, good byte dropped because FIFO was full
// master = consumer, slave = receiver.
// ---------------------------------------------------------------------------
interface tty_rx_os_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          valid;
  logic          ready;
  logic [7:0]    data;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          brk;
  logic          overrun;

  modport master (
    output valid,
    input  ready, data, count, frame_err, brk, overrun
  );

  modport slave (
    input  valid,
    output ready, data, count, frame_err, brk, overrun
  );
endinterface

// File: rtl/tty_fifo.sv
// ---------------------------------------------------------------------------
// tty_fifo
// Synchronous FIFO with registered read port, usable by both the receiver
// and a buffered transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (ignored when full unless popping same cycle)
//   push_data : byte to store
//   pop       : read head into pop_data (ignored when empty)
//   pop_data  : last popped word, held until the next pop
//   count     : entries currently held (0..DEPTH)
//   full/empty: occupancy flags
// ---------------------------------------------------------------------------
module tty_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] pop_data_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds. The read sees the old word because the write is
  // non-blocking.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = pop_data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/tty_rx_os.sv
// ---------------------------------------------------------------------------
// tty_rx_os
// 8N1 serial receiver with 16x oversampling, majority-vote bit decisions
// and a receive FIFO.
//   clk : sole clock
//   rst : synchronous active-high reset
//   rx  : asynchronous serial line, idle high, LSB first
//   bus : consumer bus (valid/ready/data/count/frame_err/brk/overrun)
// Parameters:
//   DIV   : clk cycles per 1/16 bit (2..65535)
//   DEPTH : receive FIFO entries (power of two, 2..64)
// ---------------------------------------------------------------------------
module tty_rx_os
  import tty_rx_os_pkg::*;
#(
  parameter int DIV   = DEFAULT_DIV,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  tty_rx_os_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] TICK_RELOAD = 16'(DIV - 1);

  // -------------------------------------------------------------------------
  // Input synchronizer; both flops idle high so reset never looks like a
  // start bit. rs_prev_reg only exists for falling-edge detection.
  // -------------------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic rs_prev_reg;
  logic rs;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      rs_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= rx;
      sync2_reg   <= sync1_reg;
      rs_prev_reg <= sync2_reg;
    end
  end

  assign rs   = sync2_reg;
  assign fall = rs_prev_reg && !rs;

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  rx_state_t   state_reg,      state_next;
  logic [15:0] tick_cnt_reg,   tick_cnt_next;
  logic [3:0]  sample_cnt_reg, sample_cnt_next;
  logic        s7_reg,         s7_next;
  logic        s8_reg,         s8_next;
  logic [7:0]  shift_reg,      shift_next;
  logic [2:0]  bit_idx_reg,    bit_idx_next;
  logic        frame_err_reg,  frame_err_next;
  logic        brk_reg,        brk_next;
  logic        overrun_reg,    overrun_next;
  logic        ready_reg;

  logic        tick;
  logic        mid;
  logic        wrap;
  logic        vote;
  logic        push_req;

  // FIFO handshake
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_pop_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign tick = (state_reg != ST_IDLE) && (tick_cnt_reg == '0);
  // mid: third vote sample; wrap: last sample of the bit period.
  assign mid  = tick && (sample_cnt_reg == SAMPLE_C);
  assign wrap = tick && (sample_cnt_reg == SAMPLE_LAST);
  // Samples 7 and 8 are registered; sample 9 is the live rs value.
  assign vote = maj3(s7_reg, s8_reg, rs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      tick_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      s7_reg         <= 1'b0;
      s8_reg         <= 1'b0;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      frame_err_reg  <= 1'b0;
      brk_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
      s7_reg         <= s7_next;
      s8_reg         <= s8_next;
      shift_reg      <= shift_next;
      bit_idx_reg    <= bit_idx_next;
      frame_err_reg  <= frame_err_next;
      brk_reg        <= brk_next;
      overrun_reg    <= overrun_next;
      ready_reg      <= fifo_pop;
    end
  end

  always_comb begin
    state_next      = state_reg;
    tick_cnt_next   = tick_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    s7_next         = s7_reg;
    s8_next         = s8_reg;
    shift_next      = shift_reg;
    bit_idx_next    = bit_idx_reg;
    push_req        = 1'b0;
    frame_err_next  = 1'b0;
    brk_next        = 1'b0;

    if (state_reg == ST_IDLE) begin
      // Timing restarts from the detected edge so samples stay centred.
      if (fall) begin
        state_next      = ST_START;
        tick_cnt_next   = TICK_RELOAD;
        sample_cnt_next = '0;
      end
    end else begin
      if (tick) begin
        tick_cnt_next   = TICK_RELOAD;
        sample_cnt_next = sample_cnt_reg + 4'd1;
      end else begin
        tick_cnt_next   = tick_cnt_reg - 16'd1;
      end
      if (tick && (sample_cnt_reg == SAMPLE_A)) begin
        s7_next = rs;
      end
      if (tick && (sample_cnt_reg == SAMPLE_B)) begin
        s8_next = rs;
      end

      unique case (state_reg)
        ST_START: begin
          // A start bit that votes high was only a glitch.
          if (mid && vote) begin
            state_next = ST_IDLE;
          end else if (wrap) begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
          end
        end
        ST_DATA: begin
          if (mid) begin
            shift_next = {vote, shift_reg[7:1]};
          end
          if (wrap) begin
            if (bit_idx_reg == 3'd7) begin
              state_next = ST_STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
            end
          end
        end
        ST_STOP: begin
          // Decide mid-bit and leave immediately so a start bit that
          // follows the stop bit directly is still caught.
          if (mid) begin
            state_next = ST_IDLE;
            if (vote) begin
              push_req = 1'b1;
            end else begin
              frame_err_next = 1'b1;
              brk_next       = (shift_reg == 8'h00);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO side. A pop is skipped while ready is high, which limits pops to
  // one every two cycles and keeps each ready pulse to a single cycle.
  // -------------------------------------------------------------------------
  assign fifo_pop     = bus.valid && !fifo_empty && !ready_reg;
  assign fifo_push    = push_req && (!fifo_full || fifo_pop);
  assign overrun_next = push_req && fifo_full && !fifo_pop;

  tty_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.ready     = ready_reg;
  assign bus.data      = fifo_pop_data;
  assign bus.count     = fifo_count;
  assign bus.frame_err = frame_err_reg;
  assign bus.brk       = brk_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_tty_rx_os.sv
// ---------------------------------------------------------------------------
// tb_tty_rx_os
// Scoreboard bench for tty_rx_os (DIV=4, DEPTH=8). exp_q mirrors the FIFO
// contents: bytes are pushed when a good frame has been sent and popped by
// the monitor whenever ready pulses.
// ---------------------------------------------------------------------------
module tb_tty_rx_os;
  localparam int DIV       = 4;
  localparam int DEPTH     = 8;
  localparam int BIT_CYC   = 16 * DIV;
  localparam int FRAME_CYC = 10 * BIT_CYC;
  localparam int IDLE_CYC  = 16;
  // rx changes just after posedge P0; rs falls at P2, START is entered at
  // P3 and the tick for sample k fires in cycle P(2+DIV*(k+1)).
  // The stop decision is global sample 16*9+9, so valid must be high
  // during cycle offset 2+DIV*154 to pop in the same cycle as that push.
  localparam int POP_AT_STOP = 2 + DIV * (16 * 9 + 10);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  tty_rx_os_if #(.DEPTH(DEPTH)) bus ();

  tty_rx_os #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         ready_seen = 0;
  int         ferr_seen  = 0;
  int         brk_seen   = 0;
  int         ovr_seen   = 0;
  logic [7:0] last_pop   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (bus.ready) begin
      ready_seen++;
      if (exp_q.size() == 0) begin
        chk("ready_without_data", 32'd1, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        $display("pop  data=0x%02h expected=0x%02h", bus.data, exp_b);
        chk("pop_data", {24'd0, bus.data}, {24'd0, exp_b});
        last_pop = exp_b;
      end
    end
    if (bus.frame_err) ferr_seen++;
    if (bus.brk)       brk_seen++;
    if (bus.overrun)   ovr_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; pop_at >= 0 raises valid for one cycle at that offset.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
    logic [9:0] fr;
    int r0, f0, b0, o0, exp_ovr;
    fr = {stop_bit, b, 1'b0};
    r0 = ready_seen; f0 = ferr_seen; b0 = brk_seen; o0 = ovr_seen;
    @(posedge clk);
    #1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      rx        = fr[c / BIT_CYC];
      bus.valid = (c == pop_at);
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
    rx        = 1'b1;
    idle(IDLE_CYC);
    exp_ovr = 0;
    if (stop_bit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1;
    end
    $display("send data=0x%02h stop=%0d count=%0d", b, stop_bit, bus.count);
    chk("frame_err_pulses", ferr_seen - f0, (!stop_bit) ? 1 : 0);
    chk("brk_pulses", brk_seen - b0, (!stop_bit && b == 8'h00) ? 1 : 0);
    chk("overrun_pulses", ovr_seen - o0, exp_ovr);
    chk("ready_during_frame", ready_seen - r0, (pop_at >= 0) ? 1 : 0);
    chk("count_after_frame", 32'(bus.count), exp_q.size());
  endtask

  task automatic pop_one(input int exp_ready);
    int r0;
    r0 = ready_seen;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    idle(3);
    chk("ready_pulses", ready_seen - r0, exp_ready);
    chk("count_after_pop", 32'(bus.count), exp_q.size());
    chk("data_hold", {24'd0, bus.data}, {24'd0, last_pop});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},     {31'd0, bus.ready},     32'd0);
    chk({tag, "_data"},      {24'd0, bus.data},      32'd0);
    chk({tag, "_count"},     32'(bus.count),         32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_brk"},       {31'd0, bus.brk},       32'd0);
    chk({tag, "_overrun"},   {31'd0, bus.overrun},   32'd0);
  endtask

  // Drives part of a frame, then resets mid-frame.
  task automatic send_abort(input logic [7:0] b, input int abort_at);
    logic [9:0] fr;
    int r0, f0, b0, o0;
    fr = {1'b1, b, 1'b0};
    @(posedge clk);
    #1;
    for (int c = 0; c < abort_at; c++) begin
      rx = fr[c / BIT_CYC];
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    rx  = 1'b1;
    exp_q.delete();
    idle(3);
    $display("rst  asserted mid-frame of 0x%02h", b);
    check_reset_outputs("mid_rst");
    last_pop = 8'h00;
    rst = 1'b0;
    r0 = ready_seen; f0 = ferr_seen; b0 = brk_seen; o0 = ovr_seen;
    idle(FRAME_CYC);
    chk("post_rst_pulses", (ready_seen - r0) + (ferr_seen - f0) + (brk_seen - b0) + (ovr_seen - o0), 0);
    chk("post_rst_count", 32'(bus.count), 32'd0);
  endtask

  initial begin
    bus.valid = 1'b0;
    idle(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(20);

    // Request with an empty FIFO does nothing.
    pop_one(0);

    // Single byte.
    send_frame(8'h55, 1'b1, -1);
    pop_one(1);

    // Half-bit start glitch, then a real frame.
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(BIT_CYC / 2);
    rx = 1'b1;
    idle(BIT_CYC);
    chk("glitch_count", 32'(bus.count), 32'd0);
    chk("glitch_frame_err", ferr_seen, 32'd0);
    send_frame(8'hA3, 1'b1, -1);
    pop_one(1);

    // Framing errors, the second one a break.
    send_frame(8'h3C, 1'b0, -1);
    send_frame(8'h00, 1'b0, -1);

    // Overrun on the ninth byte, then drain.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1);
    for (int i = 0; i < DEPTH; i++) pop_one(1);
    pop_one(0);

    // Full FIFO, pop coincides with the ninth stop decision.
    for (int i = 1; i <= 8; i++) send_frame(8'(8'h10 + i), 1'b1, -1);
    send_frame(8'h19, 1'b1, POP_AT_STOP);
    for (int i = 0; i < DEPTH; i++) pop_one(1);

    // Reset during data bit 4 of 0xFF, then a clean byte.
    send_abort(8'hFF, 5 * BIT_CYC + BIT_CYC / 2);
    send_frame(8'h81, 1'b1, -1);
    pop_one(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
